// File: rtl/router_pkg.sv
// Shared router constants: packet field positions and requester indices.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package router_pkg;

    // Default packet width and field positions for that width
    localparam int DATA_W  = 64;
    localparam int VC_BIT  = DATA_W - 1;
    localparam int DIR_BIT = DATA_W - 2;
    localparam int HOP_MSB = DATA_W - 9;
    localparam int HOP_LSB = DATA_W - 16;

    // Requester ordering on every output arbiter
    localparam int PE_IDX  = 0;
    localparam int CW_IDX  = 1;
    localparam int CCW_IDX = 2;

    typedef enum logic [1:0] {
        REQ_PE  = 2'd0,
        REQ_CW  = 2'd1,
        REQ_CCW = 2'd2
    } req_idx_e;

    // Saturating decrement of an 8-bit hop count: zero never wraps
    function automatic logic [7:0] sat_dec8(input logic [7:0] v);
        return (v == 8'd0) ? 8'd0 : v - 8'd1;
    endfunction

endpackage

// File: rtl/router_output_arb_if.sv
// Request/grant and outbound channel bundle for one router output port.
// Latency: n/a (wires only).
// Backpressure: ch2out_rdy travels against the packet flow.
interface router_output_arb_if #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 64
);
    logic [NUM_REQ-1:0]        in2arb_req;
    logic [NUM_REQ-1:0]        arb2in_gnt;
    logic [NUM_REQ*DATA_W-1:0] in2arb_din;
    logic                      out2ch_vld;
    logic                      ch2out_rdy;
    logic [DATA_W-1:0]         out2ch_dout;

    // Arbiter side
    modport slave (
        input  in2arb_req,
        input  in2arb_din,
        input  ch2out_rdy,
        output arb2in_gnt,
        output out2ch_vld,
        output out2ch_dout
    );

    // Requesters plus downstream channel side
    modport master (
        output in2arb_req,
        output in2arb_din,
        output ch2out_rdy,
        input  arb2in_gnt,
        input  out2ch_vld,
        input  out2ch_dout
    );
endinterface

// File: rtl/router_rr_pick.sv
// Masked round-robin one-hot pick: first request at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; caller gates the pick.
module router_rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick
);

    logic [NUM_REQ-1:0] masked;
    logic               found;

    // Prefer the lowest request at or above ptr; fall back to the lowest overall
    always_comb begin
        masked = '0;
        pick   = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            masked[i] = req[i] && (PTR_W'(i) >= ptr);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (masked[i] && !found) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && !found) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_output_arb.sv
// Round-robin arbiter + two-entry per-VC buffer for one ring output port.
// Latency: grant same cycle, capture next edge, offered when polarity == VC index.
// Backpressure: ch2out_rdy=0 holds the entry; same-VC grants stall until it drains.
// Optional: ROUTER_OUT_ARB_HOP_DEC_EN decrements the hop count and flips VC at capture.
module router_output_arb #(
    parameter int DATA_W  = router_pkg::DATA_W,
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input logic               clk,
    input logic               rst,
    input logic               polarity,
    router_output_arb_if.slave bus
);
    import router_pkg::*;

`ifdef ROUTER_OUT_ARB_HOP_DEC_EN
    localparam int VC_POS = DATA_W - 1;
    localparam int HOP_HI = DATA_W - 9;
    localparam int HOP_LO = DATA_W - 16;
`endif

    logic [DATA_W-1:0]  buf_dat [2];
    logic [1:0]         buf_empty;
    logic [PTR_W-1:0]   rr_ptr;

    logic               fill_idx;
    logic               drain_idx;
    logic [NUM_REQ-1:0] pick;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_any;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [DATA_W-1:0]  win_dat;
    logic [DATA_W-1:0]  cap_dat;
    logic               drain;

    // Upstream drains VC ~p while p is offered downstream, so the two never collide
    assign fill_idx  = ~polarity;
    assign drain_idx = polarity;

    router_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req  (bus.in2arb_req),
        .ptr  (rr_ptr),
        .pick (pick)
    );

    // Grant only into an empty fill entry; nothing is granted while in reset
    always_comb begin
        gnt_any = rst && buf_empty[fill_idx] && (|bus.in2arb_req);
        gnt     = gnt_any ? pick : '0;
    end

    assign bus.arb2in_gnt = gnt;

    // Encode the winner, select its packet and compute the pointer after it
    always_comb begin
        win_idx = '0;
        win_dat = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                win_idx = PTR_W'(i);
                win_dat = bus.in2arb_din[i*DATA_W +: DATA_W];
            end
        end
        ptr_nxt = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
    end

    // Packet as it is stored; the hop variant rewrites it for the next hop
    always_comb begin
        cap_dat = win_dat;
`ifdef ROUTER_OUT_ARB_HOP_DEC_EN
        cap_dat[HOP_HI:HOP_LO] = sat_dec8(win_dat[HOP_HI:HOP_LO]);
        cap_dat[VC_POS]        = ~win_dat[VC_POS];
`endif
    end

    assign drain           = ~buf_empty[drain_idx] && bus.ch2out_rdy;
    assign bus.out2ch_vld  = ~buf_empty[drain_idx];
    assign bus.out2ch_dout = buf_empty[drain_idx] ? '0 : buf_dat[drain_idx];

    // Buffer, occupancy and pointer state; fill and drain hit opposite entries
    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_dat[0] <= '0;
            buf_dat[1] <= '0;
            buf_empty  <= 2'b11;
            rr_ptr     <= '0;
        end else begin
            if (gnt_any) begin
                buf_dat[fill_idx]   <= cap_dat;
                buf_empty[fill_idx] <= 1'b0;
                rr_ptr              <= ptr_nxt;
            end
            if (drain) begin
                buf_empty[drain_idx] <= 1'b1;
            end
        end
    end

endmodule
